muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative HI/LO multiply/divide unit for the MIPS32 core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI and LO registers. It sits beside the EX stage, directly upstream of the register file: MFHI/MFLO select `hi`/`lo` onto the writeback WriteData path. The hazard unit stalls on `busy`.

## Interface
- `MUL_LATENCY`, default 3: cycles `busy` is held for MULT/MULTU. Legal range 1..8.
- `clock`  in  1  core clock.
- `reset`  in  1  synchronous, active-high; clock `clock`.
- `op_valid`  in  1  request strobe, qualified by `!busy`.
- `op`  in  3  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO. Codes 6 and 7 are no-ops.
- `rs_data`  in  32  operand A (dividend / multiplicand / MTxx source).
- `rt_data`  in  32  operand B (divisor / multiplier).
- `cancel`  in  1  pipeline flush (exception or branch squash); aborts the in-flight op.
- `busy`  out  1  op in progress; HI/LO not yet valid.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + accept + MULT/MULTU -> MUL.
- IDLE + accept + DIV/DIVU -> DIV.
- MUL, count done -> IDLE.
- DIV, 32 iterations done -> FIX -> IDLE.
- Any state + `cancel` -> IDLE.
- Accept condition: `op_valid && !busy && !cancel`. If `op_valid` is high while busy, it is ignored; the stall is the upstream's job.
- Operands are latched at accept. Later changes on `rs_data`/`rt_data` have no effect.
- MULT/MULTU: 64-bit signed/unsigned product of the latched operands. `{hi,lo}` = product.
- DIV/DIVU: restoring radix-2 division on magnitudes, one quotient bit per cycle, MSB first.
  - Signed: FIX negates the quotient when sign(A) xor sign(B), and negates the remainder when sign(A).
  - LO = quotient, HI = remainder.
- Divide by zero (no trap), falling out of the algorithm:
  - Magnitude quotient = 0xFFFFFFFF, remainder = |A|, then sign-fixed.
  - DIVU x/0: LO=0xFFFFFFFF, HI=x.
  - DIV 7/0: LO=0xFFFFFFFF, HI=7.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: write `rs_data` into `hi`/`lo` at the accepting edge. No busy cycle; the other register is untouched.
- HI and LO change only at op completion or on MTxx. An aborted op leaves both unchanged.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, state IDLE, iteration counter 0.
- Reset mid-operation aborts at that edge; the result is not written.
- Accept at edge E0; `busy` is high from E0 until completion.
- MUL: completes at edge E0+`MUL_LATENCY`.
- DIV: completes at edge E0+33 (32 iterations + FIX).
- At the completion edge `hi`/`lo` update and `busy` falls together. The first cycle with `busy`=0 shows the new values.
- A new op may be accepted in the first non-busy cycle (back-to-back, zero bubble).
- MTHI/MTLO: value visible on the output the cycle after accept.
- `cancel`, same cycle as `op_valid`: cancel wins, nothing accepted.
- `cancel` while busy: IDLE and `busy`=0 after the next edge.
- `cancel` in the completion cycle: the result is discarded.
- Outputs `hi`, `lo`, `busy` are registered. There is no combinational path from any input to any output.

## Structure
- Package `muldiv_pkg`:
  - op-code localparams (OP_MULT..OP_MTLO);
  - FSM state enum;
  - DIV_ITERS=32.
- Sub-module `muldiv_divider`: restoring-division datapath, i.e. remainder/quotient shift registers, the subtract-compare, and the 5-bit iteration counter. It takes start/operand magnitudes and returns quotient/remainder magnitudes plus done.
- Top level holds:
  - the FSM;
  - the multiply pipeline (a single `*` followed by `MUL_LATENCY`-1 delay registers);
  - sign fix-up;
  - HI/LO.

## Test plan
- Reset, then idle 5 cycles -> `hi`=`lo`=0, `busy`=0.
- MULT 0xFFFFFFFF × 2 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, exactly 3 cycles after accept. MULTU with the same operands -> `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIV −7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, 33 busy cycles. DIVU 100/7 -> `lo`=0xE, `hi`=0x2.
- DIVU 0x1234/0 -> `lo`=0xFFFFFFFF, `hi`=0x1234. DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Busy-drop and aborts:
  - MTLO 0xAA, then DIV 9/2 with `op_valid` held high mid-busy -> extra requests ignored.
  - `cancel` at iteration 10 -> `busy` drops next cycle, `lo` stays 0xAA, `hi` unchanged.
  - `reset` mid-MUL -> all outputs 0.
- Back-to-back MULTU 3×5 then MTHI 0x77 in the first non-busy cycle -> `lo`=0xF, `hi`=0x77 one cycle later.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and divider constants for the HI/LO unit
package muldiv_pkg;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam int DIV_ITERS = 32;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: restoring radix-2 divider on magnitudes, one quotient bit per cycle
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem,
  output logic        o_done
);
  logic [31:0] r_quo, r_rem, r_b;
  logic [4:0] r_cnt;
  logic r_active;
  logic [32:0] w_shift;
  logic [31:0] w_diff;
  logic w_ge;
  // The dividend shifts out of r_quo MSB-first while quotient bits shift in at the LSB
  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge = w_shift >= {1'b0, r_b};
  assign w_diff = w_shift[31:0] - r_b;
  assign o_done = r_active && r_cnt == 5'(DIV_ITERS - 1);
  assign o_quo = r_quo;
  assign o_rem = r_rem;
  always_ff @(posedge clock) begin
    if (reset || i_abort) begin
      r_active <= 1'b0;
      r_cnt <= 5'd0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt <= 5'd0;
      r_quo <= i_a;
      r_rem <= 32'd0;
      r_b <= i_b;
    end else if (r_active) begin
      r_quo <= {r_quo[30:0], w_ge};
      r_rem <= w_ge ? w_diff : w_shift[31:0];
      r_cnt <= r_cnt + 5'd1;
      if (o_done) r_active <= 1'b0;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS32 multiply/divide unit holding the HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t r_state, w_next;
  logic [31:0] r_a, r_b, w_quo, w_rem;
  logic r_msgn, r_neg_q, r_neg_r;
  logic [2:0] r_mcnt;
  logic [63:0] w_prod, w_tap;
  logic w_accept, w_is_mul, w_is_div, w_sdiv, w_mul_done, w_div_done;
  assign busy = r_state != IDLE;
  assign w_accept = op_valid && !busy && !cancel;
  assign w_is_mul = op == OP_MULT || op == OP_MULTU;
  assign w_is_div = op == OP_DIV || op == OP_DIVU;
  assign w_sdiv = op == OP_DIV;
  assign w_mul_done = r_state == MUL && r_mcnt == 3'(MUL_LATENCY - 1);
  // Sign-extending both operands to 64 bits lets one unsigned multiplier serve MULT and MULTU
  assign w_prod = {{32{r_msgn & r_a[31]}}, r_a} * {{32{r_msgn & r_b[31]}}, r_b};
  if (MUL_LATENCY == 1) begin : g_nopipe
    assign w_tap = w_prod;
  end else begin : g_pipe
    logic [63:0] r_pipe [MUL_LATENCY-1];
    always_ff @(posedge clock) begin
      r_pipe[0] <= w_prod;
      for (int i = 1; i < MUL_LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
    end
    assign w_tap = r_pipe[MUL_LATENCY-2];
  end
  muldiv_divider u_div (
    .clock   (clock),
    .reset   (reset),
    .i_start (w_accept && w_is_div),
    .i_abort (cancel),
    .i_a     (w_sdiv && rs_data[31] ? -rs_data : rs_data),
    .i_b     (w_sdiv && rt_data[31] ? -rt_data : rt_data),
    .o_quo   (w_quo),
    .o_rem   (w_rem),
    .o_done  (w_div_done)
  );
  always_comb begin
    w_next = r_state;
    if (cancel) w_next = IDLE;
    else case (r_state)
      IDLE: w_next = !w_accept ? IDLE : w_is_mul ? MUL : w_is_div ? DIV : IDLE;
      MUL:  w_next = w_mul_done ? IDLE : MUL;
      DIV:  w_next = w_div_done ? FIX : DIV;
      FIX:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_mcnt <= 3'd0;
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      r_state <= w_next;
      r_mcnt <= r_state == MUL ? r_mcnt + 3'd1 : 3'd0;
      if (w_accept) begin
        r_a <= rs_data;
        r_b <= rt_data;
        r_msgn <= op == OP_MULT;
        r_neg_q <= w_sdiv & (rs_data[31] ^ rt_data[31]);
        r_neg_r <= w_sdiv & rs_data[31];
      end
      if (w_accept && op == OP_MTHI) hi <= rs_data;
      if (w_accept && op == OP_MTLO) lo <= rs_data;
      if (w_mul_done && !cancel) {hi, lo} <= w_tap;
      if (r_state == FIX && !cancel) begin
        hi <= r_neg_r ? -w_rem : w_rem;
        lo <= r_neg_q ? -w_quo : w_quo;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench; a behavioural model queues expected HI/LO per op
module tb_muldiv_unit;
  import muldiv_pkg::*;
  localparam int LAT = 3;
  logic clock = 0, reset = 1, op_valid = 0, cancel = 0;
  logic [2:0] op = 0;
  logic [31:0] rs_data = 0, rt_data = 0;
  logic busy;
  logic [31:0] hi, lo;
  typedef struct {logic [31:0] hi, lo; int lat;} exp_t;
  exp_t exp_q[$];
  int tests = 0, fails = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic p_busy = 0, p_mt = 0;
  int blen = 0;

  muldiv_unit #(.MUL_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op(op), .rs_data(rs_data),
    .rt_data(rt_data), .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic pop_check(input int len, input bit with_lat);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_event: hi=%h lo=%h with no pending op", hi, lo);
    end else begin
      e = exp_q.pop_front();
      check("hi", hi, e.hi);
      check("lo", lo, e.lo);
      if (with_lat) check("busy_len", 32'(len), 32'(e.lat));
    end
  endtask

  // Monitor: an MTxx accept or a busy fall marks a point where HI/LO must match the model
  always @(negedge clock) begin
    if (p_mt) pop_check(0, 1'b0);
    if (p_busy && busy !== 1'b1) pop_check(blen, 1'b1);
    blen = (busy === 1'b1) ? blen + 1 : 0;
    p_busy = busy === 1'b1;
    p_mt = op_valid && !cancel && !reset && busy === 1'b0 && (op == OP_MTHI || op == OP_MTLO);
  end

  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl, output int lat);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    nh = m_hi; nl = m_lo; lat = 0;
    case (o)
      OP_MULT:  begin p = 64'(sa * sb); {nh, nl} = p; lat = LAT; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {nh, nl} = p; lat = LAT; end
      OP_DIV: begin
        lat = 33;
        if (b == 0) begin nl = a[31] ? 32'd1 : 32'hFFFF_FFFF; nh = a; end
        else begin nl = 32'(sa / sb); nh = 32'(sa % sb); end
      end
      OP_DIVU: begin
        lat = 33;
        if (b == 0) begin nl = 32'hFFFF_FFFF; nh = a; end
        else begin nl = a / b; nh = a % b; end
      end
      OP_MTHI: nh = a;
      OP_MTLO: nl = a;
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(posedge clock); #1; n++; end
    if (busy !== 1'b0) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int abort_at = 0, input bit by_reset = 0, input bit hammer = 0);
    logic [31:0] nh, nl;
    int lat;
    wait_idle();
    model(o, a, b, nh, nl, lat);
    op_valid = 1; op = o; rs_data = a; rt_data = b;
    @(posedge clock); #1;
    op_valid = 0; rs_data = $urandom; rt_data = $urandom;
    if (abort_at > 0 && abort_at <= lat) begin
      if (by_reset) begin m_hi = 0; m_lo = 0; end
      exp_q.push_back('{m_hi, m_lo, abort_at});
      repeat (abort_at - 1) begin @(posedge clock); #1; end
      if (by_reset) reset = 1; else cancel = 1;
      @(posedge clock); #1;
      reset = 0; cancel = 0;
    end else begin
      if (o == OP_MTHI || o == OP_MTLO || lat > 0) exp_q.push_back('{nh, nl, lat});
      m_hi = nh; m_lo = nl;
      if (hammer) begin
        for (int i = 0; i < lat - 2; i++) begin
          op_valid = 1; op = 3'($urandom_range(0, 5)); rs_data = $urandom; rt_data = $urandom;
          @(posedge clock); #1;
        end
        op_valid = 0;
      end
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 3));
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    repeat (5) @(posedge clock);
    #1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_op(OP_DIV, -32'sd7, 32'd2);
    run_op(OP_DIVU, 32'd100, 32'd7);
    run_op(OP_DIVU, 32'h1234, 32'd0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'd7, 32'd0);
    run_op(OP_DIV, -32'sd7, 32'd0);
    run_op(OP_MTLO, 32'hAA, 32'd0);
    run_op(OP_DIV, 32'd9, 32'd2, 0, 0, 1);
    run_op(OP_MTLO, 32'hAA, 32'd0);
    run_op(OP_DIV, $urandom, 32'd3, 10);
    run_op(OP_MULT, $urandom, $urandom, 0, 0, 1);
    run_op(OP_DIVU, $urandom, $urandom, 33);
    run_op(OP_MULTU, $urandom, $urandom, LAT);
    run_op(OP_MULTU, $urandom, $urandom, 1);
    wait_idle();
    op_valid = 1; op = OP_MTLO; rs_data = 32'h5555; cancel = 1;
    @(posedge clock); #1;
    op = OP_MULT; rs_data = 32'd9; rt_data = 32'd9;
    @(posedge clock); #1;
    check("cancel_blocks_accept", 32'(busy), 32'd0);
    op_valid = 0; cancel = 0;
    run_op(OP_MTHI, 32'h1357, 32'd0);
    run_op(OP_MULT, 32'd1234, 32'd5678, 2, 1);
    run_op(OP_MULTU, 32'd3, 32'd5);
    run_op(OP_MTHI, 32'h77, 32'd0);
    run_op(3'd6, 32'h1111, 32'd1);
    run_op(3'd7, 32'h2222, 32'd1);
    run_op(OP_MTLO, 32'h99, 32'd0);
    for (int k = 0; k < 40; k++)
      run_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 33)) : 0);
    wait_idle();
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin @(posedge clock); n++; end
    if (exp_q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expected results never observed, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
